// File: rtl/mem_responder_pkg.sv
// Shared types, limits and the address check for the main-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned MAX_LATENCY = 255;

  // 1 when the byte address is word aligned and lies inside a 2**aw word store.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
    logic ok;
    ok = (addr[1:0] == 2'b00);
    for (int unsigned i = 0; i < 32; i++) begin
      if ((i >= aw + 2) && addr[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the data cache refill logic and the memory responder.
interface mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  iReq;
  logic                  iWrite;
  logic [31:0]           iAddress;
  logic [DATA_WIDTH-1:0] iWriteData;
  logic                  oReady;
  logic                  oValid;
  logic [DATA_WIDTH-1:0] oReadData;
  logic                  oError;

  modport master (
    output iReq, iWrite, iAddress, iWriteData,
    input  oReady, oValid, oReadData, oError
  );

  modport slave (
    input  iReq, iWrite, iAddress, iWriteData,
    output oReady, oValid, oReadData, oError
  );
endinterface

// File: rtl/mem_responder_sync_word_ram.sv
// Single-port word storage with registered read; contents are never reset.
module sync_word_ram #(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     iCLK,
  input  logic                     iWe,
  input  logic [ADDRESS_WIDTH-1:0] iAddr,
  input  logic [DATA_WIDTH-1:0]    iWData,
  output logic [DATA_WIDTH-1:0]    oRData
);
  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  always_ff @(posedge iCLK) begin
    if (iWe) mem[iAddr] <= iWData;
    oRData <= mem[iAddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word responder: accept one request in IDLE, wait, then pulse a completion.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LATENCY       = 4
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  mem_responder_if.slave bus
);
  localparam int unsigned LAT = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                                ((LATENCY < 1) ? 1 : LATENCY);
  localparam int unsigned CW  = $clog2(LAT + 1);

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic                     accept, enter_resp;
  logic                     lat_write, lat_err;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic                     cur_write, cur_err;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]    cur_wdata;
  logic                     ram_we;
  logic [DATA_WIDTH-1:0]    ram_q;
  logic                     valid_q, error_q, rd_sel;

  // With LATENCY==1 IDLE goes straight to RESP, so the RAM must see the live request.
  always_comb begin
    if (state == IDLE) begin
      cur_write = bus.iWrite;
      cur_err   = !addr_in_range(bus.iAddress, ADDRESS_WIDTH);
      cur_addr  = bus.iAddress[ADDRESS_WIDTH+1:2];
      cur_wdata = bus.iWriteData;
    end else begin
      cur_write = lat_write;
      cur_err   = lat_err;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iReq) begin
          accept    = 1'b1;
          cnt_nxt   = CW'(LAT - 1);
          state_nxt = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CW'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP);
  assign ram_we     = enter_resp && cur_write && !cur_err;

  sync_word_ram #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .iCLK  (iCLK),
    .iWe   (ram_we),
    .iAddr (cur_addr),
    .iWData(cur_wdata),
    .oRData(ram_q)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= bus.iWrite;
        lat_err   <= !addr_in_range(bus.iAddress, ADDRESS_WIDTH);
        lat_addr  <= bus.iAddress[ADDRESS_WIDTH+1:2];
        lat_wdata <= bus.iWriteData;
      end
      valid_q <= enter_resp;
      error_q <= enter_resp && cur_err;
      rd_sel  <= enter_resp && !cur_err && !cur_write;
    end
  end

  assign bus.oReady    = (state == IDLE);
  assign bus.oValid    = valid_q;
  assign bus.oError    = error_q;
  assign bus.oReadData = rd_sel ? ram_q : '0;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=4 and LATENCY=1 instances against a timing/storage model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];

  mem_responder_if #(.DATA_WIDTH(32)) if4 ();
  mem_responder_if #(.DATA_WIDTH(32)) if1 ();

  assign if4.iReq       = req[0];
  assign if4.iWrite     = wr[0];
  assign if4.iAddress   = addr[0];
  assign if4.iWriteData = wdata[0];
  assign if1.iReq       = req[1];
  assign if1.iWrite     = wr[1];
  assign if1.iAddress   = addr[1];
  assign if1.iWriteData = wdata[1];

  mem_responder #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .LATENCY(4)) u_dut4 (
    .iCLK(clk), .iRSTn(rst_n), .bus(if4)
  );
  mem_responder #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
    .iCLK(clk), .iRSTn(rst_n), .bus(if1)
  );

  int    passed = 0;
  int    total  = 0;
  int    lat [2] = '{4, 1};
  string nm [2]  = '{"L4", "L1"};
  int    vcnt [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: a request accepted at edge e completes at edge e+LATENCY (same edge for
  // LATENCY 1); the responder is busy until the edge after completion.
  logic [31:0] mmem [2][1024];
  int          e = 0;
  bit          have [2] = '{0, 0};
  int          redge [2] = '{0, 0};
  bit          pw [2];
  bit          perr [2];
  int          pidx [2];
  logic [31:0] pdat [2];
  logic        xr [2] = '{1'b1, 1'b1};
  logic        xv [2] = '{1'b0, 1'b0};
  logic        xe [2] = '{1'b0, 1'b0};
  logic [31:0] xd [2] = '{32'h0, 32'h0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e = 0;
      for (int d = 0; d < 2; d++) begin
        have[d] = 0; xr[d] = 1'b1; xv[d] = 1'b0; xe[d] = 1'b0; xd[d] = 32'h0;
      end
    end else begin
      e++;
      for (int d = 0; d < 2; d++) begin
        xv[d] = 1'b0; xe[d] = 1'b0; xd[d] = 32'h0;
        if (req[d] && !(have[d] && (e - 1) <= redge[d])) begin
          have[d]  = 1;
          redge[d] = (lat[d] == 1) ? e : e + lat[d];
          pw[d]    = wr[d];
          perr[d]  = (addr[d] % 4 != 0) || (addr[d] >= 32'h1000);
          pidx[d]  = int'((addr[d] / 4) % 1024);
          pdat[d]  = wdata[d];
        end
        if (have[d] && e == redge[d]) begin
          xv[d] = 1'b1;
          if (perr[d])    xe[d] = 1'b1;
          else if (pw[d]) mmem[d][pidx[d]] = pdat[d];
          else            xd[d] = mmem[d][pidx[d]];
        end
        xr[d] = !(have[d] && e <= redge[d]);
      end
    end
  end

  initial begin
    logic        rdy, vld, er;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          rdy = if4.oReady; vld = if4.oValid; er = if4.oError; rd = if4.oReadData;
        end else begin
          rdy = if1.oReady; vld = if1.oValid; er = if1.oError; rd = if1.oReadData;
        end
        chk({nm[d], ".oReady"},    32'(rdy), 32'(xr[d]));
        chk({nm[d], ".oValid"},    32'(vld), 32'(xv[d]));
        chk({nm[d], ".oError"},    32'(er),  32'(xe[d]));
        chk({nm[d], ".oReadData"}, rd,       xd[d]);
        if (vld === 1'b1) vcnt[d]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one request on the LATENCY=4 instance and time its completion.
  task automatic req4(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat_seen, output logic [31:0] rdata, output logic err);
    req[0] = 1'b1; wr[0] = w; addr[0] = a; wdata[0] = d;
    @(posedge clk);
    #2;
    req[0] = 1'b0;
    lat_seen = -1; rdata = 32'hx; err = 1'bx;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (n == 0) chk("L4.ready_low_after_accept", 32'(if4.oReady), 32'h0);
      if (if4.oValid === 1'b1) begin
        lat_seen = n; rdata = if4.oReadData; err = if4.oError;
        break;
      end
    end
  endtask

  initial begin
    int          l;
    logic [31:0] rd;
    logic        er;
    int          v0;

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    for (int i = 0; i < 1024; i++) begin
      mmem[0][i] = 32'hA500_0000 | 32'(i);
      mmem[1][i] = 32'hA500_0000 | 32'(i);
      u_dut4.u_ram.mem[i] = 32'hA500_0000 | 32'(i);
      u_dut1.u_ram.mem[i] = 32'hA500_0000 | 32'(i);
    end
    mmem[0][5] = 32'hDEADBEEF; u_dut4.u_ram.mem[5] = 32'hDEADBEEF;
    mmem[0][3] = 32'h3333_3333; u_dut4.u_ram.mem[3] = 32'h3333_3333;

    // Request held on the L1 instance through reset: first accept after release.
    req[1] = 1'b1; addr[1] = 32'h20;
    #1;
    chk("reset.L4.oReady", 32'(if4.oReady), 32'h1);
    chk("reset.L4.oValid", 32'(if4.oValid), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    req[1] = 1'b0;

    req4(1'b0, 32'h14, 32'h0, l, rd, er);
    chk("read5.latency", 32'(l), 32'd4);
    chk("read5.data", rd, 32'hDEADBEEF);
    chk("read5.error", 32'(er), 32'h0);

    step();
    req4(1'b1, 32'h08, 32'h12345678, l, rd, er);
    chk("write2.latency", 32'(l), 32'd4);
    chk("write2.data", rd, 32'h0);
    step();
    req4(1'b0, 32'h08, 32'h0, l, rd, er);
    chk("read2.latency", 32'(l), 32'd4);
    chk("read2.data", rd, 32'h12345678);

    step();
    req4(1'b0, 32'h0000_1001, 32'h0, l, rd, er);
    chk("misaligned.error", 32'(er), 32'h1);
    chk("misaligned.data", rd, 32'h0);
    step();
    req4(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, l, rd, er);
    chk("out_of_range.error", 32'(er), 32'h1);
    chk("out_of_range.data", rd, 32'h0);
    chk("out_of_range.word0_kept", u_dut4.u_ram.mem[0], 32'hA500_0000);

    step();
    v0 = vcnt[0];
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h18;
    step();
    req[0] = 1'b0;
    step();
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    repeat (8) step();
    chk("wait_pulse.completions", 32'(vcnt[0] - v0), 32'd1);

    v0 = vcnt[1];
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h24;
    repeat (10) step();
    req[1] = 1'b0;
    repeat (3) step();
    chk("L1_held.completions", 32'(vcnt[1] - v0), 32'd5);

    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0C; wdata[0] = 32'hBAD0BAD0;
    step();
    req[0] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort.oReady", 32'(if4.oReady), 32'h1);
    chk("abort.oValid", 32'(if4.oValid), 32'h0);
    chk("abort.oError", 32'(if4.oError), 32'h0);
    chk("abort.oReadData", if4.oReadData, 32'h0);
    v0 = vcnt[0];
    step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("abort.no_completion", 32'(vcnt[0] - v0), 32'd0);
    chk("abort.word3_kept", u_dut4.u_ram.mem[3], 32'h3333_3333);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
